// File: rtl/cell_pair_feeder_pkg.sv
// Shared types for the cell pair feeder: cell/operand widths, opcodes and feeder FSM states.
package cell_pair_feeder_pkg;

  localparam int unsigned CellW = 8;
  localparam int unsigned OpW   = 3;
  localparam int unsigned UserW = 8;

  typedef logic [CellW-1:0] cellDepth;
  typedef logic [UserW-1:0] userInput_t;

  typedef enum logic [OpW-1:0] {
    OpAdd  = 3'd0,
    OpSub  = 3'd1,
    OpMul  = 3'd2,
    OpAnd  = 3'd3,
    OpOr   = 3'd4,
    OpXor  = 3'd5,
    OpPass = 3'd6,
    OpNop  = 3'd7
  } opcodes_t;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StFlush = 2'd2,
    StDone  = 2'd3
  } feeder_state_t;

endpackage

// File: rtl/cell_pair_feeder_out_reg.sv
// cell_out_reg: one-entry valid/ready output register holding the paired cells and beat index.
module cell_out_reg
  import cell_pair_feeder_pkg::*;
#(
  parameter int unsigned CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CellW-1:0] inCellA,
  input  logic [CellW-1:0] inCellB,
  input  logic [CNT_W-1:0] inIdx,
  input  logic             outReady,
  output logic [CellW-1:0] cellA,
  output logic [CellW-1:0] cellB,
  output logic [CNT_W-1:0] cellIdx,
  output logic             outValid
);

  cellDepth         cellA_q, cellA_d;
  cellDepth         cellB_q, cellB_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic             valid_q, valid_d;

  // The caller only loads when the slot is free, so a load always wins over a drain.
  always_comb begin
    cellA_d = cellA_q;
    cellB_d = cellB_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    if (load) begin
      cellA_d = inCellA;
      cellB_d = inCellB;
      idx_d   = inIdx;
      valid_d = 1'b1;
    end else if (outReady) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cellA_q <= '0;
      cellB_q <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      cellA_q <= cellA_d;
      cellB_q <= cellB_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
    end
  end

  assign cellA    = cellA_q;
  assign cellB    = cellB_q;
  assign cellIdx  = idx_q;
  assign outValid = valid_q;

endmodule

// File: rtl/cell_pair_feeder.sv
// Pairs two cell streams beat-for-beat into a registered processor beat with per-frame opcode.
// Optional stall counter port stall_cnt is built when CELL_FEEDER_STATS_EN is defined.
module cell_pair_feeder
  import cell_pair_feeder_pkg::*;
#(
  parameter int unsigned FRAME_CELLS = 16,
  parameter int unsigned CNT_W       = $clog2(FRAME_CELLS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [OpW-1:0]   cfg_opcode,
  input  logic [UserW-1:0] cfg_userInput,
  input  logic [CellW-1:0] a_cell,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [CellW-1:0] b_cell,
  input  logic             b_valid,
  output logic             b_ready,
  output logic [CellW-1:0] cellA,
  output logic [CellW-1:0] cellB,
  output logic [OpW-1:0]   opcode,
  output logic [UserW-1:0] userInputA,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] cell_idx,
  output logic             busy,
  output logic             frame_done
`ifdef CELL_FEEDER_STATS_EN
  ,
  output logic [15:0]      stall_cnt
`endif
);

  localparam logic [CNT_W-1:0] LastIdx = CNT_W'(FRAME_CELLS - 1);

  feeder_state_t    state_q, state_d;
  logic [CNT_W-1:0] issue_q, issue_d;
  opcodes_t         opcode_q, opcode_d;
  userInput_t       user_q, user_d;

  logic slotFree;
  logic pairFire;

  assign slotFree = !out_valid || out_ready;
  // Both streams pop together or not at all, keeping A[i] paired with B[i].
  assign pairFire = (state_q == StRun) && slotFree && a_valid && b_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      issue_q  <= '0;
      opcode_q <= OpAdd;
      user_q   <= '0;
    end else begin
      state_q  <= state_d;
      issue_q  <= issue_d;
      opcode_q <= opcode_d;
      user_q   <= user_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    issue_d  = issue_q;
    opcode_d = opcode_q;
    user_d   = user_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d  = StRun;
          issue_d  = '0;
          opcode_d = opcodes_t'(cfg_opcode);
          user_d   = cfg_userInput;
        end
      end
      StRun: begin
        if (pairFire) begin
          issue_d = issue_q + CNT_W'(1);
          if (issue_q == LastIdx) state_d = StFlush;
        end
      end
      StFlush: begin
        if (out_valid && out_ready) state_d = StDone;
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy       = (state_q == StRun);
    frame_done = (state_q == StDone);
    a_ready    = pairFire;
    b_ready    = pairFire;
    opcode     = opcode_q;
    userInputA = user_q;
  end

  cell_out_reg #(
    .CNT_W(CNT_W)
  ) u_out_reg (
    .clk     (clk),
    .rst     (rst),
    .load    (pairFire),
    .inCellA (a_cell),
    .inCellB (b_cell),
    .inIdx   (issue_q),
    .outReady(out_ready),
    .cellA   (cellA),
    .cellB   (cellB),
    .cellIdx (cell_idx),
    .outValid(out_valid)
  );

`ifdef CELL_FEEDER_STATS_EN
  logic [15:0] stall_q, stall_d;

  // Counts cycles where the output slot could take a pair but a source was missing.
  always_comb begin
    stall_d = stall_q;
    if (state_q == StIdle && start) begin
      stall_d = '0;
    end else if (state_q == StRun && slotFree && !(a_valid && b_valid) &&
                 stall_q != 16'hFFFF) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) stall_q <= '0;
    else     stall_q <= stall_d;
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_cell_pair_feeder.sv
// Scoreboard bench for cell_pair_feeder: FRAME_CELLS=4 instance for frame tests, FRAME_CELLS=1 instance for the single-cell case.
module tb_cell_pair_feeder;
  import cell_pair_feeder_pkg::*;

  localparam int unsigned FC  = 4;
  localparam int unsigned CW4 = $clog2(FC + 1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // FRAME_CELLS = 4 instance
  logic             rst, start, out_ready;
  logic [OpW-1:0]   cfgOp, opcode;
  logic [UserW-1:0] cfgUser, userInputA;
  logic [CellW-1:0] a_cell, b_cell, cellA, cellB;
  logic             a_valid, a_ready, b_valid, b_ready;
  logic             out_valid, busy, frame_done;
  logic [CW4-1:0]   cell_idx;

  // FRAME_CELLS = 1 instance
  logic             start1;
  logic [OpW-1:0]   opcode1;
  logic [UserW-1:0] userInput1;
  logic [CellW-1:0] cellA1, cellB1;
  logic             a1_ready, b1_ready, out1_valid, busy1, frame_done1;
  logic [0:0]       idx1;

`ifdef CELL_FEEDER_STATS_EN
  logic [15:0] stall_cnt, stall_cnt1;
`endif

  cell_pair_feeder #(.FRAME_CELLS(FC)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_opcode(cfgOp), .cfg_userInput(cfgUser),
    .a_cell(a_cell), .a_valid(a_valid), .a_ready(a_ready),
    .b_cell(b_cell), .b_valid(b_valid), .b_ready(b_ready),
    .cellA(cellA), .cellB(cellB), .opcode(opcode), .userInputA(userInputA),
    .out_valid(out_valid), .out_ready(out_ready), .cell_idx(cell_idx),
    .busy(busy), .frame_done(frame_done)
`ifdef CELL_FEEDER_STATS_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  cell_pair_feeder #(.FRAME_CELLS(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .cfg_opcode(OpPass), .cfg_userInput(8'd7),
    .a_cell(8'h55), .a_valid(1'b1), .a_ready(a1_ready),
    .b_cell(8'h66), .b_valid(1'b1), .b_ready(b1_ready),
    .cellA(cellA1), .cellB(cellB1), .opcode(opcode1), .userInputA(userInput1),
    .out_valid(out1_valid), .out_ready(1'b1), .cell_idx(idx1),
    .busy(busy1), .frame_done(frame_done1)
`ifdef CELL_FEEDER_STATS_EN
    , .stall_cnt(stall_cnt1)
`endif
  );

  typedef struct packed {
    logic [7:0]     a;
    logic [7:0]     b;
    logic [CW4-1:0] idx;
  } beat_t;

  beat_t          expQ[$];
  int             checks = 0;
  int             errors = 0;
  int             doneCnt = 0;
  logic [OpW-1:0] expOp;
  logic [UserW-1:0] expUser;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Source model: A[i] = 10+i, B[i] = 20+i, srcLen beats per frame.
  int ia = 0, ib = 0, srcLen = 0;
  bit aEn = 1'b1, bEn = 1'b1;
  bit fa, fb;

  always_comb begin
    a_valid = aEn && (ia < srcLen);
    a_cell  = 8'(10 + ia);
    b_valid = bEn && (ib < srcLen);
    b_cell  = 8'(20 + ib);
  end

  always begin
    @(posedge clk);
    #1;
    if (fa) ia++;
    if (fb) ib++;
  end

  // Monitor: pops the scoreboard on every accepted beat, checks holds and frame_done timing.
  beat_t held;
  bit    stalled = 1'b0;
  bit    prevLastAcc = 1'b0;

  always @(negedge clk) begin
    beat_t e;
    fa = a_valid && a_ready;
    fb = b_valid && b_ready;
    check("a_ready equals b_ready", a_ready, b_ready);
    if (frame_done) begin
      doneCnt++;
      check("frame_done follows last beat", prevLastAcc, 1);
    end
    if (stalled) check("output held under stall", {out_valid, cellA, cellB, cell_idx}, {1'b1, held});
    if (out_valid && out_ready) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected beat: got idx %0d expected none", cell_idx);
      end else begin
        e = expQ.pop_front();
        check("beat cells/idx", {cellA, cellB, cell_idx}, e);
        check("beat opcode", opcode, expOp);
        check("beat userInputA", userInputA, expUser);
      end
    end
    prevLastAcc = out_valid && out_ready && (cell_idx == CW4'(FC - 1));
    stalled     = out_valid && !out_ready;
    held        = {cellA, cellB, cell_idx};
  end

  // Cycle c = 0 is the start cycle. Windows with lo > hi are disabled; negative pulseAt/rstAt off.
  task automatic runFrame(input logic [OpW-1:0] op, input logic [UserW-1:0] usr,
                          input int bLo0, input int bLo1, input int rLo0, input int rLo1,
                          input int pulseAt, input int rstAt, input bit chkLat);
    int d0;
    bit done;
    d0   = doneCnt;
    done = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk);
      #2;
      if (doneCnt != d0) begin
        done = 1'b1;
        break;
      end
      if (c == 0) begin
        ia = 0;
        ib = 0;
        srcLen  = FC;
        expOp   = op;
        expUser = usr;
        for (int k = 0; k < FC; k++) expQ.push_back({8'(10 + k), 8'(20 + k), CW4'(k)});
      end
      start     = (c == 0) || (c == pulseAt);
      cfgOp     = (c == 0) ? op : (op ^ 3'd1);
      cfgUser   = (c == 0) ? usr : usr + 8'd1;
      bEn       = !(c >= bLo0 && c <= bLo1);
      out_ready = !(c >= rLo0 && c <= rLo1);
      rst       = (c == rstAt);
      @(negedge clk);
      if (!bEn) check("a_ready low while B stalls", {a_ready, b_ready}, 0);
      if (!out_ready && out_valid) check("ready low while output stalls", {a_ready, b_ready}, 0);
      if (chkLat && c == 1) check("no beat before latency", out_valid, 0);
      if (chkLat && c == 2) check("first beat at start+2", {out_valid, cell_idx}, {1'b1, 3'd0});
      if (rstAt >= 0 && c == rstAt + 1) begin
        check("state after reset", {out_valid, busy, frame_done, cell_idx}, 0);
        done = 1'b1;
        break;
      end
    end
    start     = 1'b0;
    bEn       = 1'b1;
    out_ready = 1'b1;
    rst       = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL frame timeout: got no frame_done expected one within 60 cycles");
    end
    if (rstAt < 0) check("no beats lost", expQ.size(), 0);
  endtask

  initial begin
    int d;
    rst = 1'b1; start = 1'b0; start1 = 1'b0; cfgOp = '0; cfgUser = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset outputs", {out_valid, busy, frame_done, a_ready, b_ready, cell_idx}, 0);
    check("reset registers", {cellA, cellB, opcode, userInputA}, 0);
    @(posedge clk);
    #2;
    rst = 1'b0;

    // Full-rate frame
    runFrame(OpXor, 8'd5, 99, -1, 99, -1, -1, -1, 1'b1);
    check("opcode holds after frame", opcode, OpXor);

    // B stalls for cycles 3..5
    runFrame(OpXor, 8'd5, 3, 5, 99, -1, -1, -1, 1'b0);
`ifdef CELL_FEEDER_STATS_EN
    check("stall_cnt", stall_cnt, 3);
`endif

    // Downstream stall for 4 cycles
    runFrame(OpMul, 8'd9, 99, -1, 3, 6, -1, -1, 1'b0);

    // start pulsed mid-frame with another opcode
    runFrame(OpSub, 8'd11, 99, -1, 99, -1, 3, -1, 1'b0);
    check("opcode ignores mid-frame start", {opcode, userInputA}, {OpSub, 8'd11});

    // Reset after two beats, then a clean frame
    runFrame(OpAnd, 8'd2, 99, -1, 99, -1, -1, 3, 1'b0);
    expQ.delete();
    d = doneCnt;
    repeat (5) @(posedge clk);
    #2;
    check("no frame_done after reset", doneCnt, d);
    runFrame(OpOr, 8'd3, 99, -1, 99, -1, -1, -1, 1'b1);

    // FRAME_CELLS = 1
    @(posedge clk); #2; start1 = 1'b1;
    @(posedge clk); #2; start1 = 1'b0;
    @(negedge clk);
    check("fc1 pair fires", {a1_ready, b1_ready, busy1}, 3'b111);
    @(posedge clk); #2;
    @(negedge clk);
    check("fc1 beat", {out1_valid, cellA1, cellB1, idx1}, {1'b1, 8'h55, 8'h66, 1'b0});
    check("fc1 no pop after last", {a1_ready, b1_ready, frame_done1}, 0);
    @(posedge clk); #2;
    @(negedge clk);
    check("fc1 frame_done", frame_done1, 1);
    check("fc1 opcode/user", {opcode1, userInput1}, {OpPass, 8'd7});
    @(posedge clk); #2;
    @(negedge clk);
    check("fc1 idle after frame", {frame_done1, out1_valid, a1_ready, b1_ready, busy1}, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
